// File: rtl/pkt_ff_rd_ctrl.sv
// Read-side controller of the async packet FIFO.
// Synchronises the write gray pointer, flags empty and issues RAM reads.
// Re-times the 1-cycle RAM read port into a valid/ready packet stream
// through a 3-entry skid buffer, and checks SOP/EOP framing.
module pkt_ff_rd_ctrl #(
  parameter int unsigned PTR_W  = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PTR_W-1:0]  wptr_gry,
  input  logic [PTR_W-1:0]  rptr,
  output logic              rd_en,
  output logic [PTR_W-2:0]  rd_addr,
  input  logic [DATA_W+1:0] rd_data,
  output logic              pkt_valid,
  input  logic              pkt_ready,
  output logic              pkt_sop,
  output logic              pkt_eop,
  output logic [DATA_W-1:0] pkt_data,
  output logic              ff_empty,
  output logic              fr_err
);

  typedef enum logic {
    ST_IDLE,
    ST_IN_PKT
  } state_t;

  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b = '0;
    b[PTR_W-1] = g[PTR_W-1];
    for (int unsigned i = 1; i < PTR_W; i++) begin
      b[PTR_W-1-i] = b[PTR_W-i] ^ g[PTR_W-1-i];
    end
    return b;
  endfunction

  function automatic logic [1:0] next_slot(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  logic [PTR_W-1:0]  wsync1_q, wsync2_q;
  logic [PTR_W-1:0]  wbin, rbin, avail;
  logic              inflight_q;
  logic [2:0]        pending;
  logic [1:0]        occ_q, occ_d;
  logic [1:0]        wr_ptr_q, wr_ptr_d;
  logic [1:0]        rd_ptr_q, rd_ptr_d;
  logic [DATA_W+1:0] buf_q [3];
  logic [DATA_W+1:0] head;
  logic              head_sop, head_eop;
  logic              push, pop;
  state_t            state_q;
  logic              fr_err_q;

  // Two-flop synchroniser for the write-domain gray pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      wsync1_q <= '0;
      wsync2_q <= '0;
    end else begin
      wsync1_q <= wptr_gry;
      wsync2_q <= wsync1_q;
    end
  end

  // Pointer arithmetic: modular distance covers full-range wrap; RAM address is the low bits
  always_comb begin
    wbin     = gray2bin(wsync2_q);
    rbin     = gray2bin(rptr);
    avail    = wbin - rbin;
    ff_empty = (avail == '0);
    rd_addr  = rbin[PTR_W-2:0];
  end

  // Read issue: words already requested count against buffer space, same-cycle pop does not
  always_comb begin
    pending = {1'b0, occ_q} + {2'b00, inflight_q};
    rd_en   = !rst && !ff_empty && (pending < 3'd3);
  end

  // Tracks the read whose data lands on rd_data next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_en;
    end
  end

  // Output buffer next-state: push landed RAM data, pop on handshake
  always_comb begin
    push     = inflight_q;
    pop      = pkt_valid && pkt_ready;
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !pop) begin
      occ_d = occ_q + 2'd1;
    end else if (pop && !push) begin
      occ_d = occ_q - 2'd1;
    end
    if (push) begin
      wr_ptr_d = next_slot(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = next_slot(rd_ptr_q);
    end
  end

  // Output buffer occupancy and pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Output buffer storage; contents are don't-care while empty so no reset
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      buf_q[wr_ptr_q] <= rd_data;
    end
  end

  // Head entry drives the stream; outputs are zeroed while nothing is buffered
  always_comb begin
    head      = buf_q[rd_ptr_q];
    head_sop  = head[DATA_W+1];
    head_eop  = head[DATA_W];
    pkt_valid = (occ_q != 2'd0);
    pkt_sop   = pkt_valid && head_sop;
    pkt_eop   = pkt_valid && head_eop;
    pkt_data  = pkt_valid ? head[DATA_W-1:0] : '0;
  end

  // Framing checker: advances on every accepted word, error flag is sticky
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      fr_err_q <= 1'b0;
    end else if (pop) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!head_sop) begin
            fr_err_q <= 1'b1;
          end else if (!head_eop) begin
            state_q <= ST_IN_PKT;
          end
        end
        ST_IN_PKT: begin
          if (head_sop) begin
            // Unexpected SOP restarts the packet after flagging the error
            fr_err_q <= 1'b1;
            state_q  <= head_eop ? ST_IDLE : ST_IN_PKT;
          end else if (head_eop) begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign fr_err = fr_err_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (occ_q == 2'd3)));

endmodule

// File: tb/tb_pkt_ff_rd_ctrl.sv
`timescale 1ns/1ps
module tb_pkt_ff_rd_ctrl;
  localparam int PTR_W  = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int W      = DATA_W + 2;
  localparam int LOGN   = 1024;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [PTR_W-1:0]  wptr_gry = '0;
  logic [PTR_W-1:0]  rptr;
  logic              rd_en;
  logic [PTR_W-2:0]  rd_addr;
  logic [W-1:0]      rd_data = '0;
  logic              pkt_valid;
  logic              pkt_ready = 1'b1;
  logic              pkt_sop, pkt_eop;
  logic [DATA_W-1:0] pkt_data;
  logic              ff_empty, fr_err;

  pkt_ff_rd_ctrl #(.PTR_W(PTR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .wptr_gry(wptr_gry), .rptr(rptr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_sop(pkt_sop),
    .pkt_eop(pkt_eop), .pkt_data(pkt_data), .ff_empty(ff_empty), .fr_err(fr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [PTR_W-1:0] to_gray(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Environment: read-pointer counter, RAM read port, and write pointer as seen after two sync stages
  logic [PTR_W-1:0] rptr_bin = '0;
  logic [W-1:0]     ram [DEPTH];
  logic [PTR_W-1:0] wh1 = '0, wh2 = '0;
  int               cyc = 0;
  assign rptr = to_gray(rptr_bin);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      rptr_bin <= '0;
      wh1      <= '0;
      wh2      <= '0;
    end else begin
      if (rd_en) begin
        rptr_bin <= rptr_bin + 1'b1;
        rd_data  <= ram[rd_addr];
      end
      wh1 <= wptr_gry;
      wh2 <= wh1;
    end
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Writer: every word put in RAM is also logged as the expected output stream
  logic [PTR_W-1:0] wptr_bin = '0;
  logic [W-1:0]     wlog [LOGN];
  int               wr_count = 0;

  function automatic bit has_space();
    logic [PTR_W-1:0] used;
    used = wptr_bin - rptr_bin;
    return int'(used) < DEPTH;
  endfunction

  task automatic wr_word(input logic s, input logic e, input logic [DATA_W-1:0] d);
    int g;
    g = 0;
    while (!has_space() && g < 200) begin
      tick();
      g++;
    end
    if (!has_space()) begin
      fails++;
      $display("FAIL write_space: got full expected space (cycle %0d)", cyc);
    end else begin
      ram[wptr_bin[PTR_W-2:0]] = {s, e, d};
      wlog[wr_count]           = {s, e, d};
      wr_count++;
      wptr_bin = wptr_bin + 1'b1;
      wptr_gry = to_gray(wptr_bin);
    end
  endtask

  // Reference model state (owned by the compare process)
  int        rd_idx = 0, issued = 0, popped = 0;
  int        total_pops = 0, total_rden = 0;
  bit        m_err = 0, m_inpkt = 0;
  bit        prev_rden = 0, prev_valid = 0, prev_hold = 0;
  logic [W+0:0] prev_out = '0;
  int        rden_rise = -1, rden_run = 0, valid_rise = -1;
  logic [PTR_W-2:0] addr_log [$];
  logic [W-1:0] w;
  bit        exp_empty, s_bit, e_bit;

  // Compare process: every cycle, check all outputs against the queue-level model
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_idx     = wr_count;
        issued     = 0;
        popped     = 0;
        m_err      = 0;
        m_inpkt    = 0;
        prev_rden  = 0;
        prev_valid = 0;
        prev_hold  = 0;
      end else begin
        exp_empty = (wh2 == rptr);
        chk("ff_empty", 64'(ff_empty), 64'(exp_empty));
        chk("rd_en", 64'(rd_en), 64'(!exp_empty && (issued - popped) < 3));
        if (rd_en) chk("rd_addr", 64'(rd_addr), 64'(rptr_bin[PTR_W-2:0]));
        chk("pkt_valid", 64'(pkt_valid), 64'((issued - (prev_rden ? 1 : 0)) > popped));
        chk("fr_err", 64'(fr_err), 64'(m_err));
        if (pkt_valid) begin
          if (rd_idx >= wr_count) begin
            fails++;
            checks++;
            $display("FAIL extra_word: got valid expected no word (cycle %0d)", cyc);
          end else begin
            w = wlog[rd_idx];
            chk("pkt_word", 64'({pkt_sop, pkt_eop, pkt_data}), 64'(w));
          end
        end else begin
          chk("idle_out", 64'({pkt_sop, pkt_eop, pkt_data}), 64'(0));
        end
        if (prev_hold) chk("hold_stable", 64'({pkt_valid, pkt_sop, pkt_eop, pkt_data}), 64'(prev_out));
        prev_hold = pkt_valid && !pkt_ready;
        prev_out  = {pkt_valid, pkt_sop, pkt_eop, pkt_data};
        if (pkt_valid && pkt_ready && rd_idx < wr_count) begin
          w     = wlog[rd_idx];
          s_bit = w[W-1];
          e_bit = w[W-2];
          if (m_inpkt ? s_bit : !s_bit) m_err = 1;
          m_inpkt = s_bit ? !e_bit : (m_inpkt && !e_bit);
          rd_idx++;
          popped++;
          total_pops++;
        end
        if (rd_en && !prev_rden) begin
          rden_rise = cyc;
          rden_run  = 1;
        end else if (rd_en) begin
          rden_run++;
        end
        if (pkt_valid && !prev_valid) valid_rise = cyc;
        if (rd_en) begin
          issued++;
          total_rden++;
          addr_log.push_back(rd_addr);
        end
        prev_rden  = rd_en;
        prev_valid = pkt_valid;
      end
    end
  end

  task automatic drain(input int target, input string name);
    int g;
    g = 0;
    while (total_pops < target && g < 300) begin
      tick();
      g++;
    end
    chk(name, 64'(total_pops), 64'(target));
  endtask

  int k, p0, t0, la, n, rem, pos;
  bit sp, ep;
  int exp_addr [4] = '{6, 7, 0, 1};

  initial begin
    rst = 1'b1;
    pkt_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rd_en", 64'(rd_en), 64'(0));
    chk("rst_valid", 64'(pkt_valid), 64'(0));
    chk("rst_data", 64'({pkt_sop, pkt_eop, pkt_data}), 64'(0));
    chk("rst_empty", 64'(ff_empty), 64'(1));
    chk("rst_fr_err", 64'(fr_err), 64'(0));

    // Single packet: pointer steps 0 -> 4 in one go
    tick();
    k  = cyc;
    p0 = total_pops;
    wr_word(1'b1, 1'b0, 32'hA000_0000);
    wr_word(1'b0, 1'b0, 32'hA000_0001);
    wr_word(1'b0, 1'b0, 32'hA000_0002);
    wr_word(1'b0, 1'b1, 32'hA000_0003);
    repeat (12) tick();
    chk("single_rden_start", 64'(rden_rise), 64'(k + 2));
    chk("single_rden_run", 64'(rden_run), 64'(4));
    chk("single_valid_start", 64'(valid_rise), 64'(k + 4));
    chk("single_count", 64'(total_pops - p0), 64'(4));
    chk("single_fr_err", 64'(fr_err), 64'(0));
    chk("single_empty", 64'(ff_empty), 64'(1));

    // Backpressure: 8 words with ready low, only 3 reads may issue
    pkt_ready = 1'b0;
    t0 = total_rden;
    p0 = total_pops;
    for (int i = 0; i < 8; i++) wr_word(i == 0, i == 7, 32'hB000_0000 + i);
    repeat (12) tick();
    @(negedge clk);
    chk("bp_reads", 64'(total_rden - t0), 64'(3));
    chk("bp_valid", 64'(pkt_valid), 64'(1));
    chk("bp_head", 64'({pkt_sop, pkt_data}), 64'({1'b1, 32'hB000_0000}));
    tick();
    pkt_ready = 1'b1;
    drain(p0 + 8, "bp_count");
    repeat (3) tick();
    chk("bp_total_reads", 64'(total_rden - t0), 64'(8));

    // Wrap: bring pointers to 14, then 4 more words cross the address and pointer wrap
    p0 = total_pops;
    wr_word(1'b1, 1'b1, 32'hC000_0000);
    wr_word(1'b1, 1'b1, 32'hC000_0001);
    drain(p0 + 2, "pre_wrap_count");
    repeat (3) tick();
    la = addr_log.size();
    p0 = total_pops;
    for (int i = 0; i < 4; i++) wr_word(i == 0, i == 3, 32'hD000_0000 + i);
    drain(p0 + 4, "wrap_count");
    repeat (4) tick();
    chk("wrap_nreads", 64'(addr_log.size()), 64'(la + 4));
    for (int i = 0; i < 4; i++) begin
      if (la + i < addr_log.size()) chk("wrap_addr", 64'(addr_log[la + i]), 64'(exp_addr[i]));
    end
    chk("wrap_empty", 64'(ff_empty), 64'(1));

    // Random ready, random gaps, well-formed packets of 1..4 words
    p0  = total_pops;
    n   = 0;
    rem = 0;
    pos = 0;
    for (int g = 0; g < 4000 && !(n == 200 && total_pops - p0 == 200); g++) begin
      tick();
      pkt_ready = 1'($urandom_range(0, 1));
      if (n < 200 && has_space() && $urandom_range(0, 3) != 0) begin
        if (rem == 0) begin
          rem = $urandom_range(1, 4);
          pos = 0;
        end
        sp = (pos == 0);
        ep = (pos == rem - 1) || (n == 199);
        wr_word(sp, ep, $urandom);
        pos++;
        if (ep) rem = 0;
        n++;
      end
    end
    pkt_ready = 1'b1;
    drain(p0 + 200, "rand_count");
    repeat (4) tick();
    chk("rand_fr_err", 64'(fr_err), 64'(0));
    chk("rand_empty", 64'(ff_empty), 64'(1));

    // Framing: no-SOP word while idle, then a second SOP inside a packet
    p0 = total_pops;
    wr_word(1'b0, 1'b0, 32'hE000_0000);
    wr_word(1'b1, 1'b0, 32'hE000_0001);
    wr_word(1'b1, 1'b0, 32'hE000_0002);
    wr_word(1'b0, 1'b1, 32'hE000_0003);
    drain(p0 + 4, "frame_count");
    repeat (5) tick();
    chk("frame_fr_err", 64'(fr_err), 64'(1));

    // Reset mid-stream with two words buffered
    pkt_ready = 1'b0;
    t0 = total_rden;
    wr_word(1'b1, 1'b0, 32'hF000_0000);
    wr_word(1'b0, 1'b1, 32'hF000_0001);
    repeat (8) tick();
    @(negedge clk);
    chk("mid_valid", 64'(pkt_valid), 64'(1));
    chk("mid_reads", 64'(total_rden - t0), 64'(2));
    tick();
    rst      = 1'b1;
    wptr_bin = '0;
    wptr_gry = '0;
    tick();
    rst       = 1'b0;
    pkt_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 64'(pkt_valid), 64'(0));
    chk("post_rst_fr_err", 64'(fr_err), 64'(0));
    chk("post_rst_empty", 64'(ff_empty), 64'(1));
    chk("post_rst_rd_en", 64'(rd_en), 64'(0));
    chk("post_rst_data", 64'(pkt_data), 64'(0));

    // Stream resumes cleanly after reset
    p0 = total_pops;
    wr_word(1'b1, 1'b1, 32'h1234_5678);
    drain(p0 + 1, "post_rst_count");
    repeat (4) tick();
    chk("final_empty", 64'(ff_empty), 64'(1));
    chk("final_fr_err", 64'(fr_err), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
